// File: rtl/syscall_pkg.sv
// Shared definitions for the syscall console-input block.
//   SYS_*   : $v0 syscall codes understood by the system-call unit
//   state_t : FSM state encoding of syscall_input
package syscall_pkg;

  localparam logic [31:0] SYS_PRINT_INT = 32'd1;
  localparam logic [31:0] SYS_PRINT_STR = 32'd4;
  localparam logic [31:0] SYS_READ_INT  = 32'd5;
  localparam logic [31:0] SYS_READ_STR  = 32'd8;
  localparam logic [31:0] SYS_EXIT      = 32'd10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INT_RD = 3'd1,
    STR_RD = 3'd2,
    FLUSH  = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/byte_packer.sv
// Little-endian byte-to-word packer for the read_string path.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clr         : empty the word buffer
//   push        : store din into lane 'lane'
//   lane        : byte lane (0 = bits [7:0])
//   din         : byte to store
//   full        : push into lane 3 this cycle (word complete)
//   full_word   : buffered word with din merged into 'lane'
//   flush_word  : buffered lanes below 'lane', zero from 'lane' upward
module byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        push,
  input  logic [1:0]  lane,
  input  logic [7:0]  din,
  output logic        full,
  output logic [31:0] full_word,
  output logic [31:0] flush_word
);

  logic [31:0] wbuf_reg;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign full_word[gi*8 +: 8]  = (lane == 2'(gi)) ? din : wbuf_reg[gi*8 +: 8];
    // The terminating NUL sits in 'lane'; anything above it is forced to zero.
    assign flush_word[gi*8 +: 8] = (2'(gi) < lane) ? wbuf_reg[gi*8 +: 8] : 8'h00;
  end

  assign full = push && (lane == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbuf_reg <= 32'h0;
    end else if (clr || full) begin
      // A completed word leaves through the write port, so the buffer restarts empty.
      wbuf_reg <= 32'h0;
    end else if (push) begin
      wbuf_reg <= full_word;
    end
  end

endmodule

// File: rtl/syscall_input.sv
// Console input side of the system-call unit: read_int ($v0=5) parses a
// signed decimal line into 'result'; read_string ($v0=8) packs bytes into
// words written to data memory at $a0, NUL-terminated, at most $a1-1 chars.
//   clk, rst_n              : clock, asynchronous active-low reset
//   sys, regv, rega, regalen: syscall request, $v0, $a0, $a1
//   in_valid/in_data/in_ready: console byte stream
//   MemWrite/Addr/Wdata     : word write port to data memory
//   result/result_we        : read_int value for $v0
//   busy/done               : not idle / one-cycle completion pulse
module syscall_input
  import syscall_pkg::*;
#(
  parameter logic [7:0] TERM_CHAR = 8'h0A
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sys,
  input  logic [31:0] regv,
  input  logic [31:0] rega,
  input  logic [31:0] regalen,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        MemWrite,
  output logic [31:0] Addr,
  output logic [31:0] Wdata,
  output logic [31:0] result,
  output logic        result_we,
  output logic        busy,
  output logic        done
);

  state_t      state_reg, state_next;
  logic [31:0] acc_reg, acc_next;
  logic        neg_reg, neg_next;
  logic        first_reg, first_next;
  logic [31:0] cnt_reg, cnt_next;
  logic [31:0] base_reg, base_next;
  logic [31:0] len_reg, len_next;
  logic        mem_we_reg, mem_we_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [31:0] result_reg, result_next;
  logic        result_we_reg, result_we_next;
  logic        done_reg, done_next;

  logic        accept;
  logic        pk_clr, pk_push, pk_full;
  logic [31:0] pk_full_word, pk_flush_word;
  logic [7:0]  digit_val;
  logic [31:0] word_addr;

  byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (pk_clr),
    .push       (pk_push),
    .lane       (cnt_reg[1:0]),
    .din        (in_data),
    .full       (pk_full),
    .full_word  (pk_full_word),
    .flush_word (pk_flush_word)
  );

  assign in_ready  = (state_reg == INT_RD) || (state_reg == STR_RD);
  assign busy      = (state_reg != IDLE);
  assign accept    = in_valid && in_ready;
  assign digit_val = in_data - 8'h30;
  assign word_addr = base_reg + {cnt_reg[31:2], 2'b00};

  assign MemWrite  = mem_we_reg;
  assign Addr      = addr_reg;
  assign Wdata     = wdata_reg;
  assign result    = result_reg;
  assign result_we = result_we_reg;
  assign done      = done_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      acc_reg       <= 32'h0;
      neg_reg       <= 1'b0;
      first_reg     <= 1'b0;
      cnt_reg       <= 32'h0;
      base_reg      <= 32'h0;
      len_reg       <= 32'h0;
      mem_we_reg    <= 1'b0;
      addr_reg      <= 32'h0;
      wdata_reg     <= 32'h0;
      result_reg    <= 32'h0;
      result_we_reg <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      neg_reg       <= neg_next;
      first_reg     <= first_next;
      cnt_reg       <= cnt_next;
      base_reg      <= base_next;
      len_reg       <= len_next;
      mem_we_reg    <= mem_we_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      result_reg    <= result_next;
      result_we_reg <= result_we_next;
      done_reg      <= done_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    acc_next       = acc_reg;
    neg_next       = neg_reg;
    first_next     = first_reg;
    cnt_next       = cnt_reg;
    base_next      = base_reg;
    len_next       = len_reg;
    mem_we_next    = 1'b0;
    addr_next      = 32'h0;
    wdata_next     = 32'h0;
    result_next    = result_reg;
    result_we_next = 1'b0;
    done_next      = 1'b0;
    pk_clr         = 1'b0;
    pk_push        = 1'b0;

    case (state_reg)
      IDLE: begin
        if (sys) begin
          if (regv == SYS_READ_INT) begin
            state_next = INT_RD;
            acc_next   = 32'h0;
            neg_next   = 1'b0;
            first_next = 1'b1;
          end else if (regv == SYS_READ_STR) begin
            // Buffers of length 0 or 1 only have room for the NUL.
            state_next = (regalen > 32'd1) ? STR_RD : FLUSH;
            cnt_next   = 32'h0;
            base_next  = rega & ~32'h3;
            len_next   = regalen;
            pk_clr     = 1'b1;
          end
        end
      end

      INT_RD: begin
        if (accept) begin
          first_next = 1'b0;
          if (in_data == TERM_CHAR) begin
            result_next    = neg_reg ? (32'h0 - acc_reg) : acc_reg;
            result_we_next = 1'b1;
            state_next     = DONE;
          end else if (in_data == 8'h2D && first_reg) begin
            neg_next = 1'b1;
          end else if (in_data >= 8'h30 && in_data <= 8'h39) begin
            acc_next = acc_reg * 32'd10 + {24'h0, digit_val};
          end
        end
      end

      STR_RD: begin
        if (accept) begin
          if (in_data == TERM_CHAR) begin
            state_next = FLUSH;
          end else begin
            pk_push  = 1'b1;
            cnt_next = cnt_reg + 32'd1;
            if (pk_full) begin
              mem_we_next = 1'b1;
              addr_next   = word_addr;
              wdata_next  = pk_full_word;
            end
            // Reserve the last buffer byte for the NUL terminator.
            if (cnt_next == len_reg - 32'd1) begin
              state_next = FLUSH;
            end
          end
        end
      end

      FLUSH: begin
        mem_we_next = 1'b1;
        addr_next   = word_addr;
        wdata_next  = pk_flush_word;
        pk_clr      = 1'b1;
        state_next  = DONE;
      end

      DONE: begin
        done_next  = 1'b1;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_syscall_input.sv
module tb_syscall_input;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sys = 1'b0;
  logic [31:0] regv = 32'h0;
  logic [31:0] rega = 32'h0;
  logic [31:0] regalen = 32'h0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h0;
  logic        in_ready;
  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] Wdata;
  logic [31:0] result;
  logic        result_we;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  // Per-operation records
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_cyc_q[$];
  int          rwe_n, rwe_cyc, done_n, done_cyc, nacc;
  logic [31:0] rwe_val;
  bit          bus_bad, busy_seen;

  syscall_input #(.TERM_CHAR(8'h0A)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sys       (sys),
    .regv      (regv),
    .rega      (rega),
    .regalen   (regalen),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .MemWrite  (MemWrite),
    .Addr      (Addr),
    .Wdata     (Wdata),
    .result    (result),
    .result_we (result_we),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic sample(input int cyc);
    if (MemWrite) begin
      wr_addr_q.push_back(Addr);
      wr_data_q.push_back(Wdata);
      wr_cyc_q.push_back(cyc);
    end else if (Addr !== 32'h0 || Wdata !== 32'h0) begin
      bus_bad = 1'b1;
    end
    if (result_we) begin
      rwe_n++;
      rwe_cyc = cyc;
      rwe_val = result;
    end
    if (done) begin
      done_n++;
      done_cyc = cyc;
    end
    if (busy) busy_seen = 1'b1;
  endtask

  // Issues one syscall and streams s, offering its first byte together with sys.
  // abort_at > 0: pull rst_n low right after that many bytes were accepted.
  task automatic run_op(input logic [31:0] v, input logic [31:0] a, input logic [31:0] len,
                        input string s, input int budget, input int abort_at);
    int idx;
    bit pend;
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
    rwe_n = 0; rwe_cyc = -1; rwe_val = 32'h0; done_n = 0; done_cyc = -100; nacc = 0;
    bus_bad = 1'b0; busy_seen = 1'b0;
    @(posedge clk); #1;
    sys = 1'b1; regv = v; rega = a; regalen = len;
    idx = 0;
    in_valid = (s.len() > 0);
    in_data  = (s.len() > 0) ? s[0] : 8'h00;
    pend = in_valid && in_ready;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(posedge clk);
      if (pend) begin
        nacc++;
        idx++;
      end
      if (abort_at > 0 && nacc == abort_at) begin
        rst_n = 1'b0;
        sys = 1'b0;
        in_valid = 1'b0;
        return;
      end
      #1;
      sys = 1'b0;
      if (idx < s.len()) begin
        in_valid = 1'b1;
        in_data  = s[idx];
      end else begin
        in_valid = 1'b0;
        in_data  = 8'h00;
      end
      sample(cyc);
      pend = in_valid && in_ready;
      if (done_n > 0 && cyc >= done_cyc + 2) break;
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic check_all_zero(input string name);
    logic [199:0] obs;
    obs = {in_ready, MemWrite, Addr, Wdata, result, result_we, busy, done};
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL %s: rdy=%b we=%b addr=%h wdata=%h result=%h rwe=%b busy=%b done=%b, required all 0",
               name, in_ready, MemWrite, Addr, Wdata, result, result_we, busy, done);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    rst_n = 1'b1;
    $display("reset: outputs checked at reset");
  endtask

  task automatic test_read_int(input string s, input logic [31:0] exp, input string name);
    run_op(32'd5, 32'h0, 32'h0, s, 60, 0);
    checks++;
    if (rwe_n !== 1 || rwe_val !== exp) begin
      errors++;
      $display("FAIL %s_result: got %h (%0d pulses), required %h (1 pulse)", name, rwe_val, rwe_n, exp);
    end
    checks++;
    if (done_n !== 1 || done_cyc !== rwe_cyc + 1) begin
      errors++;
      $display("FAIL %s_done: got %0d pulses at cycle %0d, required 1 pulse at cycle %0d",
               name, done_n, done_cyc, rwe_cyc + 1);
    end
    checks++;
    if (wr_addr_q.size() !== 0 || bus_bad) begin
      errors++;
      $display("FAIL %s_nowrite: got %0d writes bus_bad=%b, required 0 writes", name, wr_addr_q.size(), bus_bad);
    end
    $display("read_int %s: result=%h done_cycle=%0d", name, rwe_val, done_cyc);
  endtask

  task automatic check_writes(input string name, input int n,
                              input logic [31:0] a0, input logic [31:0] d0,
                              input logic [31:0] a1, input logic [31:0] d1);
    checks++;
    if (wr_addr_q.size() !== n) begin
      errors++;
      $display("FAIL %s_wcount: got %0d writes, required %0d", name, wr_addr_q.size(), n);
    end
    if (n >= 1) begin
      checks++;
      if (wr_addr_q[0] !== a0 || wr_data_q[0] !== d0) begin
        errors++;
        $display("FAIL %s_w0: got %h @%h, required %h @%h", name, wr_data_q[0], wr_addr_q[0], d0, a0);
      end
    end
    if (n >= 2) begin
      checks++;
      if (wr_addr_q[1] !== a1 || wr_data_q[1] !== d1) begin
        errors++;
        $display("FAIL %s_w1: got %h @%h, required %h @%h", name, wr_data_q[1], wr_addr_q[1], d1, a1);
      end
    end
    checks++;
    if (done_n !== 1 || wr_cyc_q.size() == 0 || done_cyc !== wr_cyc_q[wr_cyc_q.size()-1] + 1 || bus_bad) begin
      errors++;
      $display("FAIL %s_done: got %0d done pulses at cycle %0d bus_bad=%b, required 1 pulse after last write",
               name, done_n, done_cyc, bus_bad);
    end
  endtask

  task automatic test_read_string;
    run_op(32'd8, 32'h0010_0010, 32'd16, "abcdef\n", 60, 0);
    check_writes("str_abcdef", 2, 32'h0010_0010, 32'h6463_6261, 32'h0010_0014, 32'h0000_6665);
    checks++;
    if (nacc !== 7) begin
      errors++;
      $display("FAIL str_abcdef_accepted: got %0d bytes, required 7", nacc);
    end
    $display("read_string abcdef: %0d writes, %0d bytes accepted", wr_addr_q.size(), nacc);
  endtask

  task automatic test_len_limit;
    run_op(32'd8, 32'h0000_0203, 32'd5, "wxyzQ", 60, 0);
    check_writes("str_limit", 2, 32'h0000_0200, 32'h7A79_7877, 32'h0000_0204, 32'h0000_0000);
    checks++;
    if (nacc !== 4) begin
      errors++;
      $display("FAIL str_limit_accepted: got %0d bytes, required 4", nacc);
    end
    $display("read_string wxyzQ: %0d writes, %0d bytes accepted", wr_addr_q.size(), nacc);
  endtask

  task automatic test_len_one_and_bad_code;
    run_op(32'd8, 32'h0000_1008, 32'd1, "k\n", 20, 0);
    check_writes("str_len1", 1, 32'h0000_1008, 32'h0000_0000, 32'h0, 32'h0);
    checks++;
    if (nacc !== 0) begin
      errors++;
      $display("FAIL str_len1_accepted: got %0d bytes, required 0", nacc);
    end
    $display("read_string len1: %0d writes, %0d bytes accepted", wr_addr_q.size(), nacc);

    run_op(32'd7, 32'h0000_1000, 32'd8, "12\n", 10, 0);
    checks++;
    if (wr_addr_q.size() !== 0 || done_n !== 0 || busy_seen || nacc !== 0 || rwe_n !== 0) begin
      errors++;
      $display("FAIL bad_code: got writes=%0d done=%0d busy=%b accepted=%0d rwe=%0d, required all 0",
               wr_addr_q.size(), done_n, busy_seen, nacc, rwe_n);
    end
    $display("regv=7: writes=%0d done=%0d", wr_addr_q.size(), done_n);
  endtask

  task automatic test_reset_mid;
    run_op(32'd8, 32'h0000_0300, 32'd16, "abcdefgh\n", 40, 2);
    #1;
    check_all_zero("reset_mid");
    bus_bad = 1'b0;
    wr_addr_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      sample(c);
    end
    checks++;
    if (wr_addr_q.size() !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_nowrite: got %0d writes busy=%b, required 0 writes busy=0", wr_addr_q.size(), busy);
    end
    $display("reset mid-string: %0d writes after release", wr_addr_q.size());
    test_read_int("7\n", 32'd7, "after_reset");
  endtask

  initial begin
    test_reset;
    test_read_int("123\n", 32'd123, "int_123");
    test_read_int("-45\n", 32'hFFFF_FFD3, "int_neg45");
    test_read_int("4294967297\n", 32'd1, "int_wrap");
    test_read_string;
    test_len_limit;
    test_len_one_and_bad_code;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/syscall_input.md
SYSCALL_INPUT -- requirements
Module: syscall_input

Interface
REQ-001 SHALL have parameter: TERM_CHAR, 8'h0A, input terminator byte.
REQ-002 SHALL have ports: clk  in  1  rising-edge clock.
REQ-003 SHALL have: rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have: sys  in  1  syscall request; sampled only in IDLE.
REQ-005 SHALL have: regv  in  32  syscall code ($v0): 5 = read_int, 8 = read_string.
REQ-006 SHALL have: rega  in  32  string buffer byte address ($a0).
REQ-007 SHALL have: regalen  in  32  string buffer length ($a1).
REQ-008 SHALL have: in_valid  in  1 / in_data  in  8 / in_ready  out  1  console byte stream; a byte transfers when in_valid and in_ready are both high.
REQ-009 SHALL have: MemWrite  out  1 / Addr  out  32 / Wdata  out  32  word write port to data memory.
REQ-010 SHALL have: result  out  32 / result_we  out  1  read_int value for $v0.
REQ-011 SHALL have: busy  out  1 / done  out  1  busy while not in IDLE; done is a one-cycle completion pulse.

Function
REQ-012 SHALL implement the FSM states IDLE, INT_RD, STR_RD, FLUSH and DONE.
REQ-013 IDLE with sys=1: regv=5 -> INT_RD with acc=0, neg=0; regv=8 and regalen>1 -> STR_RD with cnt=0, wbuf=0, base={rega[31:2],2'b00}.
REQ-014 IDLE with sys=1: regv=8 and regalen<=1 -> FLUSH; any other regv -> ignored, stay IDLE, no done pulse.
REQ-015 in_ready SHALL be high only in INT_RD and STR_RD; a byte offered during IDLE or in the same cycle as sys is not accepted.
REQ-016 INT_RD: '-' as the first accepted byte sets neg; a digit byte d sets acc = acc*10 + d, truncated mod 2^32; other bytes are discarded.
REQ-017 INT_RD: on TERM_CHAR, result = neg ? -acc : acc and result_we pulses for 1 cycle; next state DONE.
REQ-018 STR_RD: each accepted non-terminator byte SHALL go into wbuf lane cnt[1:0] (lane0 = [7:0], little-endian, matching the string printer), then cnt increments.
REQ-019 STR_RD: when lane 3 is filled, MemWrite SHALL pulse the next cycle with Addr = base + {cnt[31:2],2'b00} and Wdata = full word; wbuf then clears.
REQ-020 STR_RD: on TERM_CHAR, or when cnt reaches regalen-1, the block SHALL go to FLUSH; the terminator byte is not stored.
REQ-021 FLUSH: write wbuf with a 0 byte in lane cnt[1:0] and upper lanes zero, for 1 cycle, at the current word address; if cnt%4==0 this is an all-zero word; next state DONE.
REQ-022 DONE: done=1 for 1 cycle; return to IDLE. sys is ignored while busy.
REQ-023 At most one MemWrite per cycle; Addr and Wdata are valid only while MemWrite=1 and are 0 otherwise.

Reset
REQ-024 rst_n low SHALL immediately force IDLE and clear acc, cnt and wbuf, and drive in_ready, MemWrite, Addr, Wdata, result, result_we, busy and done to 0.
REQ-025 Reset mid-operation SHALL abandon the transfer; no partial-word write is issued afterwards.

Structure
REQ-026 A shared package syscall_pkg SHALL hold SYS_READ_INT=5, SYS_READ_STR=8, SYS_PRINT_INT=1, SYS_PRINT_STR=4, SYS_EXIT=10 and the FSM state type.
REQ-027 Byte-lane packing (wbuf, lane select, full flag) SHALL live in one sub-module, byte_packer.

Verification
REQ-028 Scenario: read_int, bytes "123\n" -> result=123, result_we pulse, done exactly 1 cycle after result_we.
REQ-029 Scenario: read_int, bytes "-45\n" -> result=32'hFFFFFFD3; bytes "4294967297\n" -> result=1 (wrap).
REQ-030 Scenario: read_string with rega=0x00100010, regalen=16, bytes "abcdef\n" -> writes 0x64636261 @0x00100010, then 0x00006665 @0x00100014, then done.
REQ-031 Scenario: read_string with regalen=5, bytes "wxyzQ" -> write 0x7A797877 @base, then 0x00000000 @base+4; 'Q' is never accepted (in_ready low).
REQ-032 Scenario: regalen=1 -> single 0x00000000 write @base with no byte accepted; regv=7 -> no activity and no done.
REQ-033 Scenario: rst_n asserted after 2 string bytes -> outputs 0 immediately, no MemWrite; a new read_int then completes normally.
